// File: rtl/change_dispenser.sv
// change_dispenser
//   Accepts a change amount over a valid/ready handshake and releases coins
//   one at a time, greedy largest-first, as one-cycle strobes. A per-coin
//   inventory is tracked. Whatever the inventory cannot cover is reported
//   on 'short'.
//
//   Optional feature macro: CHANGE_PENNY_EN adds a penny inventory, the
//   coin_p strobe and the penny count.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; req_amount in cents
//   restock_valid     add restock_qty coins of type restock_sel (IDLE only);
//                     0 = nickel, 1 = dime, 2 = quarter, 3 = penny
//   coin_q/d/n(/p)    one-cycle coin release strobes
//   quarter/dime/nickel(/penny)
//                     coin counts of the last request
//   short             cents not dispensed on the last request
//   done              one-cycle end-of-request pulse
//   busy              high whenever the block is not idle
module change_dispenser #(
    parameter int unsigned AMT_W      = 7,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned INV_W      = 8,
    parameter int unsigned INV_INIT   = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             restock_valid,
    input  logic [1:0]       restock_sel,
    input  logic [INV_W-1:0] restock_qty,
    output logic             coin_q,
    output logic             coin_d,
    output logic             coin_n,
    output logic [CNT_W-1:0] quarter,
    output logic [CNT_W-1:0] dime,
    output logic [CNT_W-1:0] nickel,
    output logic [AMT_W-1:0] short,
    output logic             done,
    output logic             busy
`ifdef CHANGE_PENNY_EN
    ,
    output logic             coin_p,
    output logic [CNT_W-1:0] penny
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PICK_N,
        PICK_D,
        PICK_Q,
        PICK_P
    } pick_t;

    state_t           state;
    pick_t            pick;
    logic [AMT_W-1:0] rem;
    logic [3:0]       gap_cnt;
    logic [INV_W-1:0] inv_q;
    logic [INV_W-1:0] inv_d;
    logic [INV_W-1:0] inv_n;
`ifdef CHANGE_PENNY_EN
    logic [INV_W-1:0] inv_p;
`endif

    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                 input logic [INV_W-1:0] b);
        logic [INV_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[INV_W] ? '1 : s[INV_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Strobes, done, req_ready and busy are all registered alongside the
    // state so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pick      <= PICK_N;
            rem       <= '0;
            gap_cnt   <= '0;
            inv_q     <= INV_W'(INV_INIT);
            inv_d     <= INV_W'(INV_INIT);
            inv_n     <= INV_W'(INV_INIT);
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            coin_q    <= 1'b0;
            coin_d    <= 1'b0;
            coin_n    <= 1'b0;
            quarter   <= '0;
            dime      <= '0;
            nickel    <= '0;
            short     <= '0;
`ifdef CHANGE_PENNY_EN
            inv_p     <= INV_W'(INV_INIT);
            coin_p    <= 1'b0;
            penny     <= '0;
`endif
        end else begin
            coin_q <= 1'b0;
            coin_d <= 1'b0;
            coin_n <= 1'b0;
            done   <= 1'b0;
`ifdef CHANGE_PENNY_EN
            coin_p <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (restock_valid) begin
                        case (restock_sel)
                            2'd0: inv_n <= sat_add(inv_n, restock_qty);
                            2'd1: inv_d <= sat_add(inv_d, restock_qty);
                            2'd2: inv_q <= sat_add(inv_q, restock_qty);
                            default: begin
`ifdef CHANGE_PENNY_EN
                                inv_p <= sat_add(inv_p, restock_qty);
`endif
                            end
                        endcase
                    end
                    if (req_valid) begin
                        rem       <= req_amount;
                        quarter   <= '0;
                        dime      <= '0;
                        nickel    <= '0;
                        short     <= '0;
`ifdef CHANGE_PENNY_EN
                        penny     <= '0;
`endif
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    if (rem >= AMT_W'(25) && inv_q != '0) begin
                        pick   <= PICK_Q;
                        coin_q <= 1'b1;
                        state  <= S_PULSE;
                    end else if (rem >= AMT_W'(10) && inv_d != '0) begin
                        pick   <= PICK_D;
                        coin_d <= 1'b1;
                        state  <= S_PULSE;
                    end else if (rem >= AMT_W'(5) && inv_n != '0) begin
                        pick   <= PICK_N;
                        coin_n <= 1'b1;
                        state  <= S_PULSE;
`ifdef CHANGE_PENNY_EN
                    end else if (rem != '0 && inv_p != '0) begin
                        pick   <= PICK_P;
                        coin_p <= 1'b1;
                        state  <= S_PULSE;
`endif
                    end else begin
                        short <= rem;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_PULSE: begin
                    case (pick)
                        PICK_Q: begin
                            rem     <= rem - AMT_W'(25);
                            inv_q   <= inv_q - INV_W'(1);
                            quarter <= sat_inc(quarter);
                        end
                        PICK_D: begin
                            rem   <= rem - AMT_W'(10);
                            inv_d <= inv_d - INV_W'(1);
                            dime  <= sat_inc(dime);
                        end
                        PICK_N: begin
                            rem    <= rem - AMT_W'(5);
                            inv_n  <= inv_n - INV_W'(1);
                            nickel <= sat_inc(nickel);
                        end
                        default: begin
`ifdef CHANGE_PENNY_EN
                            rem   <= rem - AMT_W'(1);
                            inv_p <= inv_p - INV_W'(1);
                            penny <= sat_inc(penny);
`endif
                        end
                    endcase
                    if (GAP_CYCLES == 0) begin
                        state <= S_SELECT;
                    end else begin
                        gap_cnt <= 4'(GAP_CYCLES - 1);
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_SELECT;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_amount = '0;
    logic       req_ready;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_sel = '0;
    logic [7:0] restock_qty = '0;
    logic       coin_q, coin_d, coin_n;
    logic [3:0] quarter, dime, nickel;
    logic [6:0] short;
    logic       done, busy;

    int compared = 0;
    int mismatched = 0;

    // per-run observations: index 0 = quarter, 1 = dime, 2 = nickel
    int n_cnt[3];
    int first_e[3];
    int last_e[3];
    int done_e;

    change_dispenser #(
        .AMT_W(7), .CNT_W(4), .INV_W(8), .INV_INIT(8), .GAP_CYCLES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .restock_valid(restock_valid), .restock_sel(restock_sel),
        .restock_qty(restock_qty),
        .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
        .quarter(quarter), .dime(dime), .nickel(nickel),
        .short(short), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues one request (accept edge = edge 0) and records strobes seen
    // after each later edge until done or the cycle budget runs out.
    task automatic run_req(input int amt, input bit hold);
        logic [2:0] s;
        for (int i = 0; i < 3; i++) begin
            n_cnt[i] = 0; first_e[i] = -1; last_e[i] = -1;
        end
        done_e = -1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 7'(amt);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            @(negedge clk);
            s = {coin_n, coin_d, coin_q};
            for (int i = 0; i < 3; i++) begin
                if (s[i]) begin
                    n_cnt[i]++;
                    if (first_e[i] < 0) first_e[i] = e;
                    last_e[i] = e;
                end
            end
            if (done) begin
                done_e = e;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", req_ready); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        compared++; if ({coin_q, coin_d, coin_n} !== 3'b000) begin mismatched++; $display("FAIL reset_strobes got %b want 000", {coin_q, coin_d, coin_n}); end
        compared++; if ({quarter, dime, nickel, short} !== 19'd0) begin mismatched++; $display("FAIL reset_counts got q%0d d%0d n%0d s%0d want 0", quarter, dime, nickel, short); end
        compared++; if ({dut.inv_q, dut.inv_d, dut.inv_n} !== {8'd8, 8'd8, 8'd8}) begin mismatched++; $display("FAIL reset_inv got %0d/%0d/%0d want 8/8/8", dut.inv_q, dut.inv_d, dut.inv_n); end
    endtask

    task automatic test_fifteen();
        run_req(15, 1'b0);
        compared++; if (first_e[1] !== 1) begin mismatched++; $display("FAIL c15_dime_edge got %0d want 1", first_e[1]); end
        compared++; if (first_e[2] !== 4) begin mismatched++; $display("FAIL c15_nickel_edge got %0d want 4", first_e[2]); end
        compared++; if (done_e !== 7) begin mismatched++; $display("FAIL c15_done_edge got %0d want 7", done_e); end
        compared++; if ({quarter, dime, nickel, short} !== {4'd0, 4'd1, 4'd1, 7'd0}) begin mismatched++; $display("FAIL c15_counts got q%0d d%0d n%0d s%0d want q0 d1 n1 s0", quarter, dime, nickel, short); end
        compared++; if (n_cnt[0] + n_cnt[1] + n_cnt[2] !== 2) begin mismatched++; $display("FAIL c15_strobes got %0d want 2", n_cnt[0] + n_cnt[1] + n_cnt[2]); end
        @(posedge clk); @(negedge clk);
        compared++; if (req_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL c15_ready got r%b b%b want r1 b0", req_ready, busy); end
    endtask

    task automatic test_shortfall();
        do_reset();
        run_req(127, 1'b0);
        compared++; if (n_cnt[0] !== 5 || first_e[0] !== 1 || last_e[0] !== 13) begin mismatched++; $display("FAIL c127a_q_strobes got n%0d first%0d last%0d want n5 first1 last13", n_cnt[0], first_e[0], last_e[0]); end
        compared++; if ({quarter, dime, nickel, short} !== {4'd5, 4'd0, 4'd0, 7'd2}) begin mismatched++; $display("FAIL c127a_counts got q%0d d%0d n%0d s%0d want q5 d0 n0 s2", quarter, dime, nickel, short); end
        compared++; if (done_e !== 16) begin mismatched++; $display("FAIL c127a_done_edge got %0d want 16", done_e); end
        compared++; if (dut.inv_q !== 8'd3) begin mismatched++; $display("FAIL c127a_inv_q got %0d want 3", dut.inv_q); end
        run_req(127, 1'b0);
        compared++; if ({quarter, dime, nickel, short} !== {4'd3, 4'd5, 4'd0, 7'd2}) begin mismatched++; $display("FAIL c127b_counts got q%0d d%0d n%0d s%0d want q3 d5 n0 s2", quarter, dime, nickel, short); end
        compared++; if (dut.inv_d !== 8'd3 || dut.inv_q !== 8'd0) begin mismatched++; $display("FAIL c127b_inv got q%0d d%0d want q0 d3", dut.inv_q, dut.inv_d); end
        compared++; if (done_e !== 25 || first_e[1] !== 10) begin mismatched++; $display("FAIL c127b_timing got done%0d dime1st%0d want done25 dime1st10", done_e, first_e[1]); end
        // counts hold after done until the next accept
        repeat (3) @(negedge clk);
        compared++; if ({quarter, dime, short} !== {4'd3, 4'd5, 7'd2}) begin mismatched++; $display("FAIL c127b_hold got q%0d d%0d s%0d want q3 d5 s2", quarter, dime, short); end
    endtask

    task automatic test_zero_and_hold();
        int extra;
        do_reset();
        run_req(0, 1'b1);
        compared++; if (done_e !== 1) begin mismatched++; $display("FAIL zero_done_edge got %0d want 1", done_e); end
        compared++; if (n_cnt[0] + n_cnt[1] + n_cnt[2] !== 0 || {quarter, dime, nickel, short} !== 19'd0) begin mismatched++; $display("FAIL zero_counts got strobes%0d q%0d d%0d n%0d s%0d want all 0", n_cnt[0] + n_cnt[1] + n_cnt[2], quarter, dime, nickel, short); end
        // req_valid held through a busy 5-cent request: exactly one nickel
        run_req(5, 1'b1);
        extra = 0;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            if (coin_n || busy) extra++;
        end
        compared++; if (n_cnt[2] !== 1 || done_e !== 4 || extra !== 0) begin mismatched++; $display("FAIL hold_once got nickels%0d done%0d extra%0d want 1 4 0", n_cnt[2], done_e, extra); end
        compared++; if (dut.inv_n !== 8'd7) begin mismatched++; $display("FAIL hold_inv_n got %0d want 7", dut.inv_n); end
    endtask

    task automatic test_restock();
        do_reset();
        @(negedge clk);
        restock_valid = 1'b1; restock_sel = 2'd2; restock_qty = 8'd250;
        @(negedge clk);
        restock_valid = 1'b0;
        compared++; if (dut.inv_q !== 8'd255) begin mismatched++; $display("FAIL restock_sat got %0d want 255", dut.inv_q); end
        // selector 3 has no penny inventory in this build
        restock_valid = 1'b1; restock_sel = 2'd3; restock_qty = 8'd10;
        @(negedge clk);
        restock_valid = 1'b0;
        compared++; if ({dut.inv_q, dut.inv_d, dut.inv_n} !== {8'd255, 8'd8, 8'd8}) begin mismatched++; $display("FAIL restock_sel3 got %0d/%0d/%0d want 255/8/8", dut.inv_q, dut.inv_d, dut.inv_n); end
        // restock offered all through a busy 25-cent request
        @(negedge clk);
        req_valid = 1'b1; req_amount = 7'd25;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        restock_valid = 1'b1; restock_sel = 2'd1; restock_qty = 8'd5;
        repeat (4) @(negedge clk);
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL restock_busy_done got %b want 1", done); end
        restock_valid = 1'b0;
        @(negedge clk);
        compared++; if (dut.inv_d !== 8'd8 || dut.inv_q !== 8'd254) begin mismatched++; $display("FAIL restock_busy_inv got q%0d d%0d want q254 d8", dut.inv_q, dut.inv_d); end
        // restock of nickels together with a 5-cent request on one edge
        do_reset();
        run_req(5, 1'b0);
        run_req(5, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_amount = 7'd5;
        restock_valid = 1'b1; restock_sel = 2'd0; restock_qty = 8'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; restock_valid = 1'b0;
        repeat (4) @(negedge clk);
        compared++; if (done !== 1'b1 || nickel !== 4'd1 || dut.inv_n !== 8'd7) begin mismatched++; $display("FAIL restock_same_edge got done%b n%0d inv%0d want 1 1 7", done, nickel, dut.inv_n); end
    endtask

    task automatic test_reset_mid();
        int extra;
        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_amount = 7'd60;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        compared++; if (coin_q !== 1'b1) begin mismatched++; $display("FAIL mid_first_strobe got %b want 1", coin_q); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++; if ({req_ready, busy, done, coin_q, coin_d, coin_n} !== 6'b100000 || {quarter, dime, nickel, short} !== 19'd0) begin mismatched++; $display("FAIL mid_outputs got r%b b%b d%b s%b%b%b q%0d d%0d n%0d sh%0d want reset values", req_ready, busy, done, coin_q, coin_d, coin_n, quarter, dime, nickel, short); end
        compared++; if (dut.inv_q !== 8'd8) begin mismatched++; $display("FAIL mid_inv_q got %0d want 8", dut.inv_q); end
        extra = 0;
        repeat (2) begin @(negedge clk); if (coin_q || coin_d || coin_n) extra++; end
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); if (coin_q || coin_d || coin_n || busy) extra++; end
        compared++; if (extra !== 0) begin mismatched++; $display("FAIL mid_no_strobes got %0d want 0", extra); end
        run_req(25, 1'b0);
        compared++; if (n_cnt[0] !== 1 || quarter !== 4'd1 || done_e !== 4 || dut.inv_q !== 8'd7) begin mismatched++; $display("FAIL mid_next_req got n%0d q%0d done%0d inv%0d want 1 1 4 7", n_cnt[0], quarter, done_e, dut.inv_q); end
    endtask

    initial begin
        test_reset();
        test_fifteen();
        test_shortfall();
        test_zero_and_hold();
        test_restock();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential, parametrised successor to the combinational change calculator. It accepts a change amount over a valid/ready handshake and dispenses coins one at a time, greedy largest-first, as one-cycle release strobes, while tracking a per-coin inventory. When the inventory cannot cover the full amount, the undispensed remainder is reported. The block sits between the vending controller, which issues requests and restocks, and the coin-release actuators.

## Interface
- `AMT_W`, 7: amount width in cents.
- `CNT_W`, 4: width of the per-request coin counts.
- `INV_W`, 8: width of the per-coin inventory counters.
- `INV_INIT`, 8: inventory of each coin after reset.
- `GAP_CYCLES`, 1: idle cycles between coin strobes; range 0..15.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request amount is valid.
- `req_amount` in `AMT_W`: amount to return, in cents.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `restock_valid` in 1: add coins to inventory; acted on only in IDLE.
- `restock_sel` in 2: coin to restock; 0 = nickel, 1 = dime, 2 = quarter, 3 = penny.
- `restock_qty` in `INV_W`: number of coins to add.
- `coin_q`, `coin_d`, `coin_n` out 1 each: one-cycle release strobes.
- `quarter`, `dime`, `nickel` out `CNT_W` each: coin counts for the last request.
- `short` out `AMT_W`: cents not dispensed on the last request.
- `done` out 1: one-cycle pulse marking the end of a request.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `req_ready`=1. A handshake (`req_valid` and `req_ready` both high) loads `rem`=`req_amount`, clears the counts and `short`, then moves to SELECT.
  - SELECT: picks a quarter if `rem`≥25 and quarter inventory >0; otherwise a dime if `rem`≥10 and dime inventory >0; otherwise a nickel if `rem`≥5 and nickel inventory >0.
    - Coin picked: moves to PULSE.
    - No coin picked: `short`←`rem`, then moves to DONE.
  - PULSE: asserts the chosen strobe for exactly 1 cycle. On the exit edge, `rem` drops by the coin value, that coin's inventory drops by 1, and that coin's count rises by 1. Moves to GAP, or straight to SELECT when `GAP_CYCLES`=0.
  - GAP: waits `GAP_CYCLES` cycles, then moves to SELECT.
  - DONE: `done`=1 for 1 cycle, then moves to IDLE.
- Outputs are Moore-decoded from registered state. Strobes are never glitching combinational terms.
- The counts and `short` hold stable from DONE until the next accepted request.
- Counts saturate at 2^`CNT_W`−1. Dispensing continues when a count saturates.
- Restock adds `restock_qty` to the selected inventory, saturating at 2^`INV_W`−1. Restock is ignored outside IDLE.
- Restock and request accept on the same IDLE edge: both take effect, and SELECT uses the updated inventory.
- `req_valid` while busy is ignored; the requester holds the request.
- Amount 0 goes IDLE→SELECT→DONE, with zero counts and `short`=0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `done`=0, all strobes 0, counts 0, `short`=0, every inventory = `INV_INIT`.
- Reset mid-request aborts immediately: no further strobes, and inventory returns to `INV_INIT`.
- Latency: counting the accept edge as edge 0, `done` is high after edge k·(2+`GAP_CYCLES`)+1, where k is the number of coins dispensed. `req_ready` is high again the following cycle.
- Strobe spacing: consecutive strobes are exactly 2+`GAP_CYCLES` cycles apart.

## Configuration
- `CHANGE_PENNY_EN`, defined:
  - Adds output `coin_p` (1 bit), output `penny` (`CNT_W` bits) and a penny inventory.
  - SELECT falls through to a penny when `rem`≥1 and penny inventory >0.
  - `restock_sel`=3 restocks pennies.
- `CHANGE_PENNY_EN`, undefined:
  - The `coin_p` and `penny` ports and the penny inventory do not exist.
  - `restock_sel`=3 is ignored.
  - `rem` mod 5 always ends up in `short`.

## Test plan
- Reset, then request 15 with `GAP_CYCLES`=1 → `coin_d` strobe after edge 1 and `coin_n` strobe after edge 4; `done` after edge 7 with `dime`=1, `nickel`=1, `quarter`=0, `short`=0.
- Request 127 (no penny macro) → 5 `coin_q` strobes; `quarter`=5, `short`=2; quarter inventory drops from 8 to 3.
- Second request of 127 → `quarter`=3, `dime`=5, `short`=2; dime inventory drops to 3.
- Request 0 → `done` after edge 1 with all counts 0 and no strobes. `req_valid` held high during busy is not accepted twice.
- Restock quarters by 250 from an inventory of 8 → inventory saturates at 255. A restock during busy leaves inventory unchanged.
- Pull `rst_n` low between two strobes of a 60-cent request → strobes stop immediately, outputs return to reset values, and the next request of 25 dispenses 1 quarter.
